// File: rtl/ppu_bg_fetch_ctrl_if.sv
// VRAM read bus between the background fetch sequencer and VRAM.
interface ppu_bg_fetch_ctrl_if;
  logic [13:0] vram_addr;
  logic        vram_rd;
  logic [7:0]  vram_rdata;

  modport master (output vram_addr, output vram_rd, input vram_rdata);
  modport slave  (input vram_addr, input vram_rd, output vram_rdata);
endinterface

// File: rtl/ppu_bg_fetch_ctrl.sv
// PPU background fetch sequencer: dot/scanline counters, scroll register v,
// 8-dot nametable/attribute/pattern fetch cadence and shift-register strobes.
// Optional feature macro: PPU_ODD_FRAME_SKIP_EN (drops dot 340 of the
// pre-render line on odd frames while rendering is enabled).
module ppu_bg_fetch_ctrl #(
  parameter int unsigned DOTS  = 341,
  parameter int unsigned LINES = 262
) (
  input  logic                clk,
  input  logic                rst_n,
  ppu_bg_fetch_ctrl_if.master vram,
  input  logic                dot_en,
  input  logic                render_en,
  input  logic                bg_table_sel,
  input  logic [14:0]         t_addr,
  output logic [7:0]          tile_lo,
  output logic [7:0]          tile_hi,
  output logic [1:0]          attr_bits,
  output logic                sr_load,
  output logic                sr_shift,
  output logic [8:0]          dot,
  output logic [8:0]          scanline,
  output logic                vblank,
  output logic                frame_start
);

  localparam int unsigned CW = 9;
  localparam int unsigned AW = 14;
  localparam int unsigned VW = 15;

  localparam logic [CW-1:0] LAST_DOT  = CW'(DOTS - 1);
  localparam logic [CW-1:0] LAST_LINE = CW'(LINES - 1);
  localparam logic [CW-1:0] LAST_VIS  = 9'd239;
  localparam logic [CW-1:0] VBL_LINE  = 9'd241;

  logic [VW-1:0] v_q, v_nx;
  logic [7:0]    nt_q, nt_nx;
  logic          odd_q, odd_nx;
  logic [AW-1:0] addr_q, addr_nx;
  logic          rd_q, rd_nx;
  logic [7:0]    lo_nx, hi_nx;
  logic [1:0]    attr_nx;
  logic          load_nx, shift_nx, vbl_nx, fs_nx;
  logic [CW-1:0] dot_nx, line_nx;
  logic          cur_render, cur_fetch, nxt_render, nxt_fetch;
  logic [2:0]    cur_phase, nxt_phase;
  logic          skip, end_line;

  assign vram.vram_addr = addr_q;
  assign vram.vram_rd   = rd_q;

  function automatic logic fetch_dot(input logic [CW-1:0] d);
    return ((d >= 9'd1) && (d <= 9'd256)) || ((d >= 9'd321) && (d <= 9'd336));
  endfunction

  // Next-dot counters, scroll register updates, fetch latches and strobes.
  always_comb begin
    cur_render = (scanline <= LAST_VIS) || (scanline == LAST_LINE);
    cur_fetch  = fetch_dot(dot);
    cur_phase  = 3'(dot - 9'd1);

`ifdef PPU_ODD_FRAME_SKIP_EN
    skip = (scanline == LAST_LINE) && odd_q && render_en && (dot == LAST_DOT - 9'd1);
`else
    skip = 1'b0;
`endif
    end_line = (dot == LAST_DOT) || skip;

    dot_nx  = end_line ? '0 : dot + 9'd1;
    line_nx = scanline;
    odd_nx  = odd_q;
    if (end_line) begin
      if (scanline == LAST_LINE) begin
        line_nx = '0;
        odd_nx  = ~odd_q;
      end else begin
        line_nx = scanline + 9'd1;
      end
    end

    nxt_render = (line_nx <= LAST_VIS) || (line_nx == LAST_LINE);
    nxt_fetch  = fetch_dot(dot_nx);
    nxt_phase  = 3'(dot_nx - 9'd1);

    v_nx    = v_q;
    nt_nx   = nt_q;
    lo_nx   = tile_lo;
    hi_nx   = tile_hi;
    attr_nx = attr_bits;

    // Work belonging to the dot that is ending.
    if (render_en && cur_render) begin
      if (cur_fetch) begin
        case (cur_phase)
          3'd1: nt_nx   = vram.vram_rdata;
          3'd3: attr_nx = 2'(vram.vram_rdata >> {v_q[6], v_q[1], 1'b0});
          3'd5: lo_nx   = vram.vram_rdata;
          3'd7: begin
            hi_nx = vram.vram_rdata;
            if (v_nx[4:0] == 5'd31) begin
              v_nx[4:0] = 5'd0;
              v_nx[10]  = ~v_nx[10];
            end else begin
              v_nx[4:0] = v_nx[4:0] + 5'd1;
            end
          end
          default: ;
        endcase
      end
      if (dot == 9'd256) begin
        if (v_nx[14:12] != 3'd7) begin
          v_nx[14:12] = v_nx[14:12] + 3'd1;
        end else begin
          v_nx[14:12] = 3'd0;
          if (v_nx[9:5] == 5'd29) begin
            v_nx[9:5] = 5'd0;
            v_nx[11]  = ~v_nx[11];
          end else if (v_nx[9:5] == 5'd31) begin
            v_nx[9:5] = 5'd0;
          end else begin
            v_nx[9:5] = v_nx[9:5] + 5'd1;
          end
        end
      end
      if (dot == 9'd257) begin
        v_nx[10]  = t_addr[10];
        v_nx[4:0] = t_addr[4:0];
      end
      if ((scanline == LAST_LINE) && (dot >= 9'd280) && (dot <= 9'd304)) begin
        v_nx[14:11] = t_addr[14:11];
        v_nx[9:5]   = t_addr[9:5];
      end
    end

    // Outputs for the dot being entered.
    addr_nx = addr_q;
    rd_nx   = 1'b0;
    if (render_en && nxt_render && nxt_fetch) begin
      case (nxt_phase)
        3'd0: begin
          addr_nx = {2'b10, v_nx[11:0]};
          rd_nx   = 1'b1;
        end
        3'd2: begin
          addr_nx = {2'b10, v_nx[11:10], 4'b1111, v_nx[9:7], v_nx[4:2]};
          rd_nx   = 1'b1;
        end
        3'd4: begin
          addr_nx = {1'b0, bg_table_sel, nt_nx, 1'b0, v_nx[14:12]};
          rd_nx   = 1'b1;
        end
        3'd6: begin
          addr_nx = {1'b0, bg_table_sel, nt_nx, 1'b1, v_nx[14:12]};
          rd_nx   = 1'b1;
        end
        default: ;
      endcase
    end

    load_nx  = render_en && nxt_render && (dot_nx[2:0] == 3'd1) &&
               (((dot_nx >= 9'd9) && (dot_nx <= 9'd257)) ||
                ((dot_nx >= 9'd329) && (dot_nx <= 9'd337)));
    shift_nx = render_en && nxt_render &&
               (((dot_nx >= 9'd2) && (dot_nx <= 9'd257)) ||
                ((dot_nx >= 9'd322) && (dot_nx <= 9'd337)));

    vbl_nx = vblank;
    if ((line_nx == VBL_LINE) && (dot_nx == 9'd1)) begin
      vbl_nx = 1'b1;
    end else if ((line_nx == LAST_LINE) && (dot_nx == 9'd1)) begin
      vbl_nx = 1'b0;
    end
    fs_nx = (line_nx == '0) && (dot_nx == '0);
  end

  // State and output registers; pulses clear on clocks without a dot strike.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dot         <= '0;
      scanline    <= '0;
      v_q         <= '0;
      nt_q        <= '0;
      odd_q       <= 1'b0;
      addr_q      <= '0;
      rd_q        <= 1'b0;
      tile_lo     <= '0;
      tile_hi     <= '0;
      attr_bits   <= '0;
      sr_load     <= 1'b0;
      sr_shift    <= 1'b0;
      vblank      <= 1'b0;
      frame_start <= 1'b0;
    end else if (dot_en) begin
      dot         <= dot_nx;
      scanline    <= line_nx;
      v_q         <= v_nx;
      nt_q        <= nt_nx;
      odd_q       <= odd_nx;
      addr_q      <= addr_nx;
      rd_q        <= rd_nx;
      tile_lo     <= lo_nx;
      tile_hi     <= hi_nx;
      attr_bits   <= attr_nx;
      sr_load     <= load_nx;
      sr_shift    <= shift_nx;
      vblank      <= vbl_nx;
      frame_start <= fs_nx;
    end else begin
      rd_q        <= 1'b0;
      sr_load     <= 1'b0;
      sr_shift    <= 1'b0;
      frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ppu_bg_fetch_ctrl.sv
// Bench for ppu_bg_fetch_ctrl: random stimulus against a dot-level reference model.
module tb_ppu_bg_fetch_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dot_en = 1'b1;
  logic        render_en = 1'b0;
  logic        bg_table_sel = 1'b0;
  logic [14:0] t_addr = '0;
  logic [7:0]  tile_lo, tile_hi;
  logic [1:0]  attr_bits;
  logic        sr_load, sr_shift, vblank, frame_start;
  logic [8:0]  dot, scanline;

  ppu_bg_fetch_ctrl_if bus();

  ppu_bg_fetch_ctrl dut (
    .clk(clk), .rst_n(rst_n), .vram(bus), .dot_en(dot_en), .render_en(render_en),
    .bg_table_sel(bg_table_sel), .t_addr(t_addr), .tile_lo(tile_lo), .tile_hi(tile_hi),
    .attr_bits(attr_bits), .sr_load(sr_load), .sr_shift(sr_shift), .dot(dot),
    .scanline(scanline), .vblank(vblank), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  // reference model state
  int m_dot, m_line, m_v, m_nt, m_odd, m_frame;
  logic [13:0] e_addr;
  logic [7:0]  e_lo, e_hi;
  logic [1:0]  e_attr;
  logic        e_rd, e_load, e_shift, e_vbl, e_fs;

  int nvec = 0, nmis = 0;
  int strikes = 0, rd_cnt = 0, quiet_cnt = 0;
  bit checking = 0, fresh = 0, fs_seen = 0, done = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic bit render_line(int l);
    return (l <= 239) || (l == 261);
  endfunction

  function automatic bit fetch_dot(int d);
    return (d >= 1 && d <= 256) || (d >= 321 && d <= 336);
  endfunction

  function automatic int coarse_x(int v);
    if ((v & 31) == 31) return (v & ~31) ^ 'h400;
    return v + 1;
  endfunction

  function automatic int fine_y(int v);
    int cy = (v >> 5) & 31;
    if (((v >> 12) & 7) < 7) return v + 'h1000;
    v = v & ~'h7000;
    if (cy == 29) return (v & ~'h3E0) ^ 'h800;
    if (cy == 31) return v & ~'h3E0;
    return v + 'h20;
  endfunction

  task automatic model_reset();
    m_dot = 0; m_line = 0; m_v = 0; m_nt = 0; m_odd = 0; m_frame = 0;
    e_addr = '0; e_lo = '0; e_hi = '0; e_attr = '0;
    e_rd = 0; e_load = 0; e_shift = 0; e_vbl = 0; e_fs = 0;
  endtask

  task automatic model_strike();
    int rdata = int'(bus.vram_rdata);
    int ph;
    bit last;
    if (render_en && render_line(m_line)) begin
      if (fetch_dot(m_dot)) begin
        ph = (m_dot - 1) % 8;
        if (ph == 1) m_nt = rdata;
        if (ph == 3) e_attr = 2'((rdata >> (2 * (2 * ((m_v >> 6) & 1) + ((m_v >> 1) & 1)))) & 3);
        if (ph == 5) e_lo = 8'(rdata);
        if (ph == 7) begin e_hi = 8'(rdata); m_v = coarse_x(m_v); end
      end
      if (m_dot == 256) m_v = fine_y(m_v);
      if (m_dot == 257) m_v = (m_v & ~'h41F) | (int'(t_addr) & 'h41F);
      if (m_line == 261 && m_dot >= 280 && m_dot <= 304)
        m_v = (m_v & ~'h7BE0) | (int'(t_addr) & 'h7BE0);
    end
    last = (m_dot == 340);
`ifdef PPU_ODD_FRAME_SKIP_EN
    if (m_line == 261 && m_odd == 1 && render_en && m_dot == 339) last = 1;
`endif
    if (!last) m_dot++;
    else begin
      m_dot = 0;
      if (m_line == 261) begin m_line = 0; m_odd ^= 1; m_frame++; end
      else m_line++;
    end
    e_rd = 0; e_load = 0; e_shift = 0;
    e_fs = (m_line == 0 && m_dot == 0);
    if (m_line == 241 && m_dot == 1) e_vbl = 1;
    if (m_line == 261 && m_dot == 1) e_vbl = 0;
    if (render_en && render_line(m_line)) begin
      if (fetch_dot(m_dot) && ((m_dot - 1) % 2 == 0)) begin
        e_rd = 1;
        case ((m_dot - 1) % 8)
          0: e_addr = 14'('h2000 | (m_v & 'hFFF));
          2: e_addr = 14'('h23C0 | (((m_v >> 10) & 3) << 10) | (((m_v >> 7) & 7) << 3) | ((m_v >> 2) & 7));
          4: e_addr = 14'((int'(bg_table_sel) << 12) | (m_nt << 4) | ((m_v >> 12) & 7));
          default: e_addr = 14'((int'(bg_table_sel) << 12) | (m_nt << 4) | 8 | ((m_v >> 12) & 7));
        endcase
      end
      e_load  = ((m_dot - 1) % 8 == 0) && ((m_dot >= 9 && m_dot <= 257) || m_dot == 329 || m_dot == 337);
      e_shift = (m_dot >= 2 && m_dot <= 257) || (m_dot >= 322 && m_dot <= 337);
    end
  endtask

  // Cycle-by-cycle compare against the model, plus pinned literal expectations.
  always @(negedge clk) begin
    if (checking) begin
      check("cycle", {bus.vram_addr, bus.vram_rd, tile_lo, tile_hi, attr_bits, sr_load,
                      sr_shift, dot, scanline, vblank, frame_start},
                     {e_addr, e_rd, e_lo, e_hi, e_attr, e_load, e_shift,
                      9'(m_dot), 9'(m_line), e_vbl, e_fs});
      if (m_frame == 0 && m_line == 0 && m_dot >= 1 && m_dot <= 8 && bus.vram_rd) rd_cnt++;
      if (m_frame == 0 && m_line >= 200 && m_line <= 260 && (bus.vram_rd || sr_load || sr_shift))
        quiet_cnt++;
      if (frame_start && !fs_seen) begin
        fs_seen = 1;
        check("first_frame_start_strikes", strikes, 89342);
      end
      if (fresh && m_frame == 0) begin
        if (m_line == 0) begin
          if (m_dot == 1) check("nt_addr_d1", bus.vram_addr, 14'h2000);
          if (m_dot == 3) check("at_addr_d3", bus.vram_addr, 14'h23C0);
          if (m_dot == 5) check("lo_addr_d5", bus.vram_addr, 14'h05A0);
          if (m_dot == 7) check("hi_addr_d7", bus.vram_addr, 14'h05A8);
          if (m_dot == 9) begin
            check("sr_load_d9", sr_load, 1);
            check("rd_pulses_d1_8", rd_cnt, 4);
          end
        end
        if (m_line == 16 && m_dot == 5) check("attr_bits_e4", attr_bits, 2'b10);
        if (m_line == 241 && m_dot == 0) check("vblank_pre_241_1", vblank, 0);
        if (m_line == 241 && m_dot == 1) check("vblank_set", vblank, 1);
        if (m_line == 261 && m_dot == 0) begin
          check("vblank_pre_261_1", vblank, 1);
          check("quiet_when_disabled", quiet_cnt, 0);
        end
        if (m_line == 261 && m_dot == 1) check("vblank_clr", vblank, 0);
        if (m_line == 261 && m_dot == 321) check("prefetch_x30", bus.vram_addr, 14'h23BE);
        if (m_line == 261 && m_dot == 329) check("prefetch_x31", bus.vram_addr, 14'h23BF);
      end
      if (fresh && m_frame == 1 && m_line == 0) begin
        if (m_dot == 1) check("x_wrap_h_toggle", bus.vram_addr, 14'h27A0);
        if (m_dot == 321) check("y29_wrap_v_toggle", bus.vram_addr, 14'h281E);
        if (m_dot == 325) check("fine_y_wrap", bus.vram_addr[2:0], 3'd0);
      end
    end
  end

  initial begin
    bus.vram_rdata = '0;
    for (int cyc = 0; cyc < 98000 && !done; cyc++) begin
      @(posedge clk);
      fresh = 0;
      if (!rst_n) model_reset();
      else if (dot_en) begin model_strike(); strikes++; fresh = 1; end
      else begin e_rd = 0; e_load = 0; e_shift = 0; e_fs = 0; end
      checking = 1;
      #1;
      if (cyc == 1) begin
        check("rst_vram_addr", bus.vram_addr, 0);
        check("rst_vram_rd", bus.vram_rd, 0);
        check("rst_tiles", {tile_lo, tile_hi, attr_bits}, 0);
        check("rst_strobes", {sr_load, sr_shift, vblank, frame_start}, 0);
        check("rst_counters", {dot, scanline}, 0);
      end
      if (cyc >= 1) rst_n = 1'b1;
      if (m_frame == 1 && m_line == 0 && m_dot >= 330) done = 1;

      dot_en = ($urandom_range(47, 0) != 0);
      if (m_frame == 0 && m_line <= 16) begin
        render_en = 1'b1;
        bg_table_sel = 1'b0;
        t_addr = 15'h001E;
      end else begin
        if (m_frame == 0 && m_line >= 200 && m_line <= 260) render_en = 1'b0;
        else if (m_frame >= 1 || m_line == 261) render_en = 1'b1;
        else if ($urandom_range(399, 0) == 0) render_en = ~render_en;
        bg_table_sel = 1'($urandom_range(1, 0));
        if (m_frame >= 1 || (m_line == 261 && m_dot >= 200)) t_addr = 15'h73BE;
        else t_addr = 15'($urandom);
      end
      if (m_frame == 0 && m_line == 0) bus.vram_rdata = 8'h5A;
      else if (m_frame == 0 && m_line == 16) bus.vram_rdata = 8'hE4;
      else bus.vram_rdata = 8'($urandom);
    end
    dot_en = 1'b0;
    check("run_complete", done, 1);
    check("frame_start_seen", fs_seen, 1);
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/ppu_bg_fetch_ctrl.md
# ppu_bg_fetch_ctrl

Background fetch sequencer for the PPU. It owns the dot and scanline counters and the scroll address register v. It issues the nametable, attribute and pattern VRAM reads in the fixed 8-dot cadence, and drives load/shift enables for the background pattern and attribute shift registers. It sits between the dot-rate clock divider and the background shift-register datapath.

## Interface
- DOTS, default 341, dots per scanline
- LINES, default 262, scanlines per frame
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- dot_en  in  1  one-clk PPU dot strike from clock divider; all state advances only when high
- render_en  in  1  background rendering enable (PPUMASK bit 3)
- bg_table_sel  in  1  background pattern table select (PPUCTRL bit 4)
- t_addr  in  15  loopy t (temp scroll address), owned by register-port logic
- vram_rdata  in  8  VRAM read data
- vram_addr  out  14  VRAM read address
- vram_rd  out  1  read strobe, one clk wide
- tile_lo, tile_hi  out  8 each  latched pattern bytes for next shift-register load
- attr_bits  out  2  palette bits selected from latched attribute byte
- sr_load  out  1  one-clk pulse: load shift registers from tile_lo/tile_hi/attr_bits
- sr_shift  out  1  one-clk pulse: shift background registers
- dot  out  9  current dot, 0..DOTS-1
- scanline  out  9  current line, 0..LINES-1
- vblank  out  1  vertical blank flag
- frame_start  out  1  one-clk pulse when (scanline, dot) becomes (0, 0)

## Operation
- Counters: dot increments per dot_en and wraps DOTS-1 -> 0, incrementing scanline; scanline wraps LINES-1 -> 0 and toggles the internal odd_frame bit.
- Render lines: 0-239 and pre-render line 261. Fetch dots: 1-256 and 321-336. Phase = (dot-1) mod 8.
- Phase 0: vram_addr = 0x2000 | v[11:0].
- Phase 1: latch nt = vram_rdata.
- Phase 2: vram_addr = 0x23C0 | v[11:10]<<10 | v[9:7]<<3 | v[4:2].
- Phase 3: latch the attribute byte. attr_bits = byte >> ({v[6],v[1]}*2), using v before the phase-7 increment.
- Phase 4: vram_addr = bg_table_sel<<12 | nt<<4 | 0<<3 | v[14:12].
- Phase 5: latch tile_lo.
- Phase 6: vram_addr = the phase-4 address | 8.
- Phase 7: latch tile_hi, then increment coarse X. v[4:0] wraps 31 -> 0 and toggles v[10].
- sr_load: dots 9,17,...,257 and 329,337 on render lines.
- sr_shift: dots 2-257 and 322-337 on render lines.
- Dot 256: fine Y increment, applied after coarse X.
  - v[14:12] < 7: increment.
  - Otherwise v[14:12] = 0, then coarse Y v[9:5]:
    - 29 -> 0, toggle v[11].
    - 31 -> 0, no toggle.
    - Any other value -> +1.
- Dot 257: v[10] and v[4:0] take t_addr.
- Line 261, dots 280-304: v[14:11] and v[9:5] take t_addr on every dot.
- vblank: set entering (241, 1); cleared entering (261, 1).
- render_en = 0:
  - vram_rd, sr_load and sr_shift stay 0.
  - v and the latches hold.
  - Counters, vblank and frame_start continue.
- render_en changing mid-line takes effect on the next dot; no partial-fetch recovery.

## Timing
- Reset values:
  - dot = 0, scanline = 0, v = 0, odd_frame = 0.
  - vram_addr = 0, vram_rd = 0.
  - tile_lo = 0, tile_hi = 0, attr_bits = 0.
  - sr_load = 0, sr_shift = 0, vblank = 0, frame_start = 0.
- All outputs are registered and update at the clk edge where dot_en = 1, taking the values for the new dot.
- vram_rd is high for exactly the one clk after that edge, and only on even-phase fetch dots. vram_addr holds for the whole dot.
- Read latency: vram_rdata must be valid at the dot_en edge that ends the following odd-phase dot, at most 2 dots after the request. Latched outputs change at that edge.
- sr_load, sr_shift and frame_start are one-clk pulses following the dot_en edge entering the named dot.
- If dot_en is held high every clk, the block runs at full clock rate with identical sequencing.
- Reset mid-frame returns everything to the reset values on the next clk edge, regardless of dot_en.

## Configuration
- PPU_ODD_FRAME_SKIP_EN defined:
  - On line 261 with odd_frame = 1 and render_en = 1, dot 339 advances directly to (0, 0). Dot 340 is skipped, making that frame 1 dot short.
  - odd_frame toggles and frame_start pulses as on a normal wrap.
- Not defined: every frame is DOTS*LINES dots.

## Test plan
- Reset with rst_n = 0 for 2 clks, dot_en every clk: all outputs match the reset values; the first frame_start occurs after exactly 341*262 dot_en strikes.
- render_en = 1, t_addr = 0, vram_rdata = 0x5A on line 0:
  - dot 1: vram_addr = 0x2000.
  - dot 3: vram_addr = 0x23C0.
  - dot 5: vram_addr = 0x05A0 (bg_table_sel = 0).
  - dot 7: vram_addr = 0x05A8.
  - sr_load at dot 9.
  - vram_rd pulses exactly 4 times in dots 1-8.
- v[4:0] = 31, v[10] = 0, phase-7 increment: v[4:0] = 0 and v[10] = 1. Coarse Y = 29, fine Y = 7 at dot 256: coarse Y = 0, fine Y = 0, v[11] toggled.
- Attribute byte 0xE4 with {v[6],v[1]} = 2'b10: attr_bits = 2'b10.
- Run to line 241: vblank rises on the dot_en entering dot 1 and falls entering (261, 1). render_en = 0 throughout: vram_rd, sr_load and sr_shift are never asserted.
- With PPU_ODD_FRAME_SKIP_EN and render_en = 1: the second frame (odd_frame = 1) has 89341 dots; with render_en = 0 it has 89342. Without the macro, both frames have 89342 dots.
